axi_read_master: RTL
====================

AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, RDATA and rd_data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, ARADDR and cmd_addr width in bits.
REQ-003 The block SHALL use one clock, ACLK, and an asynchronous, active-high reset, ARESET.
REQ-004 The block SHALL have the following ports (name  direction  width  meaning):
- ACLK  in  1  clock, rising-edge active
- ARESET  in  1  asynchronous active-high reset
- cmd_valid  in  1  read command offered
- cmd_ready  out  1  command accepted when cmd_valid=1 on the same edge
- cmd_addr  in  ADDR_WIDTH  burst start address
- cmd_len  in  8  beats minus 1
- cmd_size  in  3  log2 bytes per beat
- ARADDR  out  ADDR_WIDTH  AXI read address
- ARLEN  out  8  AXI burst length
- ARSIZE  out  3  AXI beat size
- ARVALID  out  1  address valid
- ARREADY  in  1  slave address ready
- RDATA  in  DATA_WIDTH  read data
- RRESP  in  2  read response
- RLAST  in  1  slave last beat
- RVALID  in  1  read data valid
- RREADY  out  1  master data ready
- rd_data  out  DATA_WIDTH  beat data to the consumer
- rd_valid  out  1  beat valid to the consumer
- rd_ready  in  1  consumer ready
- rd_last  out  1  final beat, taken from the internal beat count
- done  out  1  one-cycle pulse at burst end
- done_resp  out  2  worst-case response of the finished burst

Function
REQ-005 The FSM SHALL have exactly the states IDLE, RADDR, RDATA and DONE.
REQ-006 cmd_ready SHALL be 1 only in IDLE.
REQ-007 A command handshake SHALL latch addr, len and size.
REQ-008 A legal command SHALL move IDLE to RADDR.
REQ-009 A command SHALL be illegal if either condition holds:
- cmd_size > log2(DATA_WIDTH/8)
- cmd_addr[11:0] + ((cmd_len+1) << cmd_size) > 4096 (4KB crossing)
REQ-010 An illegal command SHALL go IDLE to DONE with done_resp=2'b10 and SHALL produce no AR or R activity.
REQ-011 ARVALID SHALL be registered, asserted the cycle after entry to RADDR, and held with ARADDR, ARLEN and ARSIZE stable until ARREADY=1.
REQ-012 On the ARVALID&&ARREADY edge the block SHALL deassert ARVALID and go RADDR to RDATA.
REQ-013 In RDATA the block SHALL drive RREADY=rd_ready, rd_valid=RVALID and rd_data=RDATA combinationally, with zero latency and no buffering.
REQ-014 In RDATA a beat SHALL be counted on RVALID&&RREADY.
REQ-015 rd_last SHALL equal rd_valid && (beat count == latched len).
REQ-016 done_resp SHALL accumulate the numeric maximum of RRESP over all beats.
REQ-017 If RLAST differs from (beat count == len) on any beat, the block SHALL set done_resp to max(current, 2'b10).
REQ-018 On the beat where beat count == len, the block SHALL go RDATA to DONE whatever RLAST is.
REQ-019 DONE SHALL last exactly one cycle with done=1 and done_resp valid, then return to IDLE.
REQ-020 done_resp SHALL hold its value until the next command is accepted, and SHALL be cleared to 0 on acceptance.
REQ-021 Outside RDATA, RREADY and rd_valid SHALL be 0, and the block SHALL ignore RVALID.
REQ-022 Back-to-back commands SHALL be allowed: cmd_ready returns one cycle after done.

Reset
REQ-023 While ARESET=1 the block SHALL be in IDLE with these output values:
- ARVALID, RREADY, rd_valid, rd_last, done = 0
- ARADDR, ARLEN, ARSIZE, done_resp = 0
- cmd_ready = 0
REQ-024 A reset during RADDR or RDATA SHALL abandon the burst with no done pulse.
REQ-025 cmd_ready SHALL return to 1 on the first ACLK edge after ARESET deasserts.

Verification
REQ-026 The bench SHALL cover at least these scenarios:
- Single beat: addr=0x0010, len=0, size=2, ARREADY=1 immediately, RRESP=0, RLAST=1 -> one AR handshake, one rd_last beat, done pulse, done_resp=0.
- Burst with backpressure: len=7, ARREADY delayed 3 cycles, rd_ready toggling -> ARVALID held 3 cycles with stable ARADDR, 8 beats in order, RREADY mirrors rd_ready, done after the 8th handshake.
- Error merge: len=3, RRESP sequence 0,1,2,0 -> done_resp=2'b10.
- 4KB crossing: addr=0x0FF0, len=7, size=2 -> no ARVALID, done one cycle after acceptance, done_resp=2'b10.
- RLAST mismatch: len=3, slave asserts RLAST on beat 2 -> 4 beats accepted, done_resp=2'b10.
- Mid-burst reset: ARESET asserted after beat 1 of len=7 -> outputs 0 immediately, no done, cmd_ready=1 on the first edge after release.

Source files
------------

// File: rtl/axi_read_master_if.sv
// Bus bundle for axi_read_master: command intake, AXI AR/R channels and the
// consumer-side beat stream.
//   master modport: the read master (drives cmd_ready, AR*, RREADY, rd_*, done*)
//   slave modport : the environment (drives cmd_*, ARREADY, R*, rd_ready)
interface axi_read_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic [2:0]            cmd_size;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_last;
  logic                  done;
  logic [1:0]            done_resp;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size,
    output cmd_ready,
    output ARADDR, ARLEN, ARSIZE, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output rd_data, rd_valid, rd_last, done, done_resp,
    input  rd_ready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_size,
    input  cmd_ready,
    input  ARADDR, ARLEN, ARSIZE, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  rd_data, rd_valid, rd_last, done, done_resp,
    output rd_ready
  );
endinterface

// File: rtl/axi_read_master.sv
// Single-burst AXI read master. Accepts one command, checks it for an
// oversized beat or a 4KB crossing, issues one AR, streams R beats straight
// through to the consumer, and reports the worst response with a done pulse.
// Ports:
//   ACLK   - clock, rising edge
//   ARESET - asynchronous active-high reset
//   bus    - axi_read_master_if.master (command, AR, R, consumer stream, done)
module axi_read_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi_read_master_if.master bus
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam int unsigned OFF_W    = 17;  // holds 4095 + (256 << 7)
  localparam int unsigned PAGE     = 4096;

  typedef enum logic [1:0] {IDLE, RADDR, RDATA, DONE} state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [2:0]            arsize_q;
  logic [7:0]            beat_q;
  logic                  done_q;
  logic [1:0]            resp_q, resp_d;

  logic                  cmd_fire;
  logic                  cmd_legal;
  logic                  beat_fire;
  logic                  beat_last;
  logic [OFF_W-1:0]      span;
  logic [OFF_W-1:0]      end_off;

  // Command legality: beat no wider than the bus, burst stays inside its 4KB page
  assign span      = (OFF_W'(bus.cmd_len) + OFF_W'(1)) << bus.cmd_size;
  assign end_off   = OFF_W'(bus.cmd_addr[11:0]) + span;
  assign cmd_legal = (bus.cmd_size <= 3'(MAX_SIZE)) && (end_off <= OFF_W'(PAGE));

  assign cmd_fire  = bus.cmd_valid && cmd_ready_q;
  assign beat_fire = (state_q == RDATA) && bus.RVALID && bus.rd_ready;
  assign beat_last = (beat_q == arlen_q);

  // Zero-latency pass-through of the R channel, live only in RDATA
  assign bus.RREADY   = (state_q == RDATA) && bus.rd_ready;
  assign bus.rd_valid = (state_q == RDATA) && bus.RVALID;
  assign bus.rd_data  = bus.RDATA;
  assign bus.rd_last  = bus.rd_valid && beat_last;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.ARVALID   = arvalid_q;
  assign bus.ARADDR    = araddr_q;
  assign bus.ARLEN     = arlen_q;
  assign bus.ARSIZE    = arsize_q;
  assign bus.done      = done_q;
  assign bus.done_resp = resp_q;

  // Next state and next worst-case response
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          state_d = cmd_legal ? RADDR : DONE;
          resp_d  = cmd_legal ? 2'b00 : 2'b10;
        end
      end
      RADDR: begin
        if (arvalid_q && bus.ARREADY) state_d = RDATA;
      end
      RDATA: begin
        if (beat_fire) begin
          if (bus.RRESP > resp_d) resp_d = bus.RRESP;
          // Slave framing disagreeing with our own count is a slave error
          if ((bus.RLAST != beat_last) && (resp_d < 2'b10)) resp_d = 2'b10;
          if (beat_last) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      beat_q      <= '0;
      done_q      <= 1'b0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      arvalid_q   <= (state_d == RADDR);
      done_q      <= (state_d == DONE);
      resp_q      <= resp_d;
      if (cmd_fire) begin
        araddr_q <= bus.cmd_addr;
        arlen_q  <= bus.cmd_len;
        arsize_q <= bus.cmd_size;
        beat_q   <= '0;
      end else if (beat_fire) begin
        beat_q <= beat_q + 8'd1;
      end
    end
  end

endmodule
